// File: rtl/packet_parser_if.sv
`default_nettype none
// ============================================================================
// Module  : packet_parser_if
// Purpose : Bundles the UART byte stream and loader bus of packet_parser.
//           master : the parser side (consumes rx bytes, drives loader bus)
//           slave  : the surrounding system (drives rx bytes, consumes bus)
// Signals : en, rx_ready, rx_data            -> parser
//           addr_out, data_out, write_tick,
//           success_tick, error_tick, err_code,
//           busy, current_state, current_count <- parser
// Revision: 1.0 - initial release
// ============================================================================
interface packet_parser_if #(
  parameter int ADDR_BYTES  = 1,
  parameter int COUNT_BYTES = 1
);
  localparam int ADDR_W  = 8 * ADDR_BYTES;
  localparam int COUNT_W = 8 * COUNT_BYTES;

  logic               en;
  logic               rx_ready;
  logic [7:0]         rx_data;
  logic [ADDR_W-1:0]  addr_out;
  logic [7:0]         data_out;
  logic               write_tick;
  logic               success_tick;
  logic               error_tick;
  logic [1:0]         err_code;
  logic               busy;
  logic [3:0]         current_state;
  logic [COUNT_W-1:0] current_count;

  modport master (
    input  en, rx_ready, rx_data,
    output addr_out, data_out, write_tick, success_tick, error_tick,
           err_code, busy, current_state, current_count
  );

  modport slave (
    output en, rx_ready, rx_data,
    input  addr_out, data_out, write_tick, success_tick, error_tick,
           err_code, busy, current_state, current_count
  );
endinterface
`default_nettype wire

// File: rtl/packet_parser.sv
`default_nettype none
// ============================================================================
// Module  : packet_parser
// Purpose : Parses framed packets from the UART receiver
//             [chk][addr x ADDR_BYTES][count x COUNT_BYTES][data x count+1]
//           into registered address/data write strobes, then reports the
//           packet result (success_tick or error_tick + err_code).
// Ports   : clk           system clock
//           reset_n       asynchronous active-low reset
//           bus (master)  en/rx_ready/rx_data in; loader bus, result ticks,
//                         busy and debug state/count out
// Options : PACKET_PARSER_CRC8_EN - when defined the checksum byte is a
//           CRC-8 (poly 0x07, init 0) over address, count and data bytes;
//           otherwise all packet bytes must sum to 0x00 modulo 256.
// Revision: 1.0 - initial release
// ============================================================================
module packet_parser #(
  parameter int ADDR_BYTES     = 1,
  parameter int COUNT_BYTES    = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  packet_parser_if.master bus
);

  localparam int ADDR_W  = 8 * ADDR_BYTES;
  localparam int COUNT_W = 8 * COUNT_BYTES;
  localparam int HDR_MAX = (ADDR_BYTES > COUNT_BYTES) ? ADDR_BYTES : COUNT_BYTES;
  localparam int HDR_W   = (HDR_MAX > 1) ? $clog2(HDR_MAX) : 1;
  localparam int TMO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [HDR_W-1:0] ADDR_LAST  = HDR_W'(ADDR_BYTES - 1);
  localparam logic [HDR_W-1:0] COUNT_LAST = HDR_W'(COUNT_BYTES - 1);
  // The abort fires on the edge where the idle count would reach TIMEOUT_CYCLES.
  localparam logic [TMO_W-1:0] TMO_LAST   =
    TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_CNT      = 4'd2,
    ST_DATA     = 4'd3,
    ST_VALIDATE = 4'd4
  } state_t;

  state_t             state_q,        state_d;
  logic               rx_ready_q,     rx_ready_d;
  logic [ADDR_W-1:0]  addr_q,         addr_d;       // header base, then running write address
  logic [COUNT_W-1:0] cnt_q,          cnt_d;        // remaining data bytes minus 1
  logic [HDR_W-1:0]   hdr_q,          hdr_d;        // header byte index within ADDR/CNT
  logic [TMO_W-1:0]   tmo_q,          tmo_d;
  logic [7:0]         acc_q,          acc_d;        // running checksum / CRC
  logic [ADDR_W-1:0]  addr_out_q,     addr_out_d;
  logic [7:0]         data_out_q,     data_out_d;
  logic               write_tick_q,   write_tick_d;
  logic               success_tick_q, success_tick_d;
  logic               error_tick_q,   error_tick_d;
  logic [1:0]         err_code_q,     err_code_d;

  logic               accept;
  logic [7:0]         acc_next;
  logic               chk_good;

  // One byte per rising edge of rx_ready, however long it stays high.
  assign accept = bus.rx_ready & ~rx_ready_q;

`ifdef PACKET_PARSER_CRC8_EN
  logic [7:0] rx_chk_q, rx_chk_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign acc_next = crc8_byte(acc_q, bus.rx_data);
  assign chk_good = (acc_q == rx_chk_q);
`else
  assign acc_next = acc_q + bus.rx_data;
  assign chk_good = (acc_q == 8'h00);
`endif

  always_comb begin
    state_d        = state_q;
    rx_ready_d     = bus.rx_ready;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    hdr_d          = hdr_q;
    tmo_d          = tmo_q;
    acc_d          = acc_q;
    addr_out_d     = addr_out_q;
    data_out_d     = data_out_q;
    write_tick_d   = 1'b0;
    success_tick_d = 1'b0;
    error_tick_d   = 1'b0;
    err_code_d     = err_code_q;
`ifdef PACKET_PARSER_CRC8_EN
    rx_chk_d       = rx_chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept && bus.en) begin
          state_d    = ST_ADDR;
          hdr_d      = '0;
          tmo_d      = '0;
          err_code_d = 2'd0;
`ifdef PACKET_PARSER_CRC8_EN
          // The checksum byte is kept aside; the CRC covers the rest.
          rx_chk_d   = bus.rx_data;
          acc_d      = 8'h00;
`else
          acc_d      = bus.rx_data;
`endif
        end
      end

      ST_ADDR: begin
        if (accept) begin
          addr_d = (addr_q << 8) | ADDR_W'(bus.rx_data);
          acc_d  = acc_next;
          if (hdr_q == ADDR_LAST) begin
            hdr_d   = '0;
            state_d = ST_CNT;
          end else begin
            hdr_d = hdr_q + HDR_W'(1);
          end
        end
      end

      ST_CNT: begin
        if (accept) begin
          cnt_d = (cnt_q << 8) | COUNT_W'(bus.rx_data);
          acc_d = acc_next;
          if (hdr_q == COUNT_LAST) begin
            hdr_d   = '0;
            state_d = ST_DATA;
          end else begin
            hdr_d = hdr_q + HDR_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          acc_d        = acc_next;
          addr_out_d   = addr_q;
          data_out_d   = bus.rx_data;
          write_tick_d = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
          if (cnt_q == '0) begin
            state_d = ST_VALIDATE;
          end else begin
            cnt_d = cnt_q - COUNT_W'(1);
          end
        end
      end

      ST_VALIDATE: begin
        state_d = ST_IDLE;
        if (chk_good) begin
          success_tick_d = 1'b1;
        end else begin
          error_tick_d = 1'b1;
          err_code_d   = 2'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Inter-byte timeout; an accepted byte in the same cycle takes priority.
    if (TIMEOUT_CYCLES > 0) begin
      if (state_q == ST_ADDR || state_q == ST_CNT || state_q == ST_DATA) begin
        if (accept) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d        = '0;
          state_d      = ST_IDLE;
          error_tick_d = 1'b1;
          err_code_d   = 2'd2;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      rx_ready_q     <= 1'b0;
      addr_q         <= '0;
      cnt_q          <= '0;
      hdr_q          <= '0;
      tmo_q          <= '0;
      acc_q          <= '0;
      addr_out_q     <= '0;
      data_out_q     <= '0;
      write_tick_q   <= 1'b0;
      success_tick_q <= 1'b0;
      error_tick_q   <= 1'b0;
      err_code_q     <= 2'd0;
`ifdef PACKET_PARSER_CRC8_EN
      rx_chk_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      hdr_q          <= hdr_d;
      tmo_q          <= tmo_d;
      acc_q          <= acc_d;
      addr_out_q     <= addr_out_d;
      data_out_q     <= data_out_d;
      write_tick_q   <= write_tick_d;
      success_tick_q <= success_tick_d;
      error_tick_q   <= error_tick_d;
      err_code_q     <= err_code_d;
`ifdef PACKET_PARSER_CRC8_EN
      rx_chk_q       <= rx_chk_d;
`endif
    end
  end

  assign bus.addr_out      = addr_out_q;
  assign bus.data_out      = data_out_q;
  assign bus.write_tick    = write_tick_q;
  assign bus.success_tick  = success_tick_q;
  assign bus.error_tick    = error_tick_q;
  assign bus.err_code      = err_code_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.current_state = state_q;
  assign bus.current_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_packet_parser
// Purpose : Self-checking bench for packet_parser. Instance A uses 1-byte
//           address/count with a 100-cycle timeout; instance B uses 2-byte
//           address/count with the timeout disabled.
// Revision: 1.0 - initial release
// ============================================================================
module tb_packet_parser;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  packet_parser_if #(.ADDR_BYTES(1), .COUNT_BYTES(1)) bus_a ();
  packet_parser_if #(.ADDR_BYTES(2), .COUNT_BYTES(2)) bus_b ();

  packet_parser #(.ADDR_BYTES(1), .COUNT_BYTES(1), .TIMEOUT_CYCLES(100)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  packet_parser #(.ADDR_BYTES(2), .COUNT_BYTES(2), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  // Observers: log every write and count every result pulse.
  wr_t wq_a[$];
  wr_t wq_b[$];
  int  succ_a = 0, err_a = 0, succ_b = 0, err_b = 0;

  always @(negedge clk) begin
    if (bus_a.write_tick === 1'b1) wq_a.push_back(wr_t'({8'h00, bus_a.addr_out, bus_a.data_out}));
    if (bus_b.write_tick === 1'b1) wq_b.push_back(wr_t'({bus_b.addr_out, bus_b.data_out}));
    if (bus_a.success_tick === 1'b1) succ_a++;
    if (bus_a.error_tick   === 1'b1) err_a++;
    if (bus_b.success_tick === 1'b1) succ_b++;
    if (bus_b.error_tick   === 1'b1) err_b++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- accessors ----------------
  function automatic int succ_of(input bit sel); return sel ? succ_b : succ_a; endfunction
  function automatic int err_of(input bit sel);  return sel ? err_b  : err_a;  endfunction
  function automatic int wsize_of(input bit sel); return sel ? wq_b.size() : wq_a.size(); endfunction
  function automatic wr_t wget(input bit sel, input int idx); return sel ? wq_b[idx] : wq_a[idx]; endfunction
  function automatic logic [1:0] errc_of(input bit sel); return sel ? bus_b.err_code : bus_a.err_code; endfunction
  function automatic logic busy_of(input bit sel); return sel ? bus_b.busy : bus_a.busy; endfunction

  task automatic set_rx(input bit sel, input logic rdy, input logic [7:0] d);
    if (sel) begin bus_b.rx_ready = rdy; bus_b.rx_data = d; end
    else     begin bus_a.rx_ready = rdy; bus_a.rx_data = d; end
  endtask

  task automatic set_en(input bit sel, input logic v);
    if (sel) bus_b.en = v; else bus_a.en = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    set_rx(sel, 1'b1, b);
    repeat (hold) @(negedge clk);
    set_rx(sel, 1'b0, b);
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // CRC-8 as polynomial division of the message bit stream, MSB first.
  function automatic logic [7:0] crc8_msg(input bq_t m, input int from);
    logic [7:0] crc = 8'h00;
    logic       fb;
    for (int i = from; i < m.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[7] ^ m[i][b];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return crc;
  endfunction

  function automatic bit model_good(input bq_t p);
`ifdef PACKET_PARSER_CRC8_EN
    return p[0] == crc8_msg(p, 1);
`else
    int s = 0;
    for (int i = 0; i < p.size(); i++) s += int'(p[i]);
    return (s % 256) == 0;
`endif
  endfunction

  function automatic logic [7:0] good_chk(input bq_t p);
`ifdef PACKET_PARSER_CRC8_EN
    return crc8_msg(p, 1);
`else
    int s = 0;
    for (int i = 1; i < p.size(); i++) s += int'(p[i]);
    return 8'((256 - (s % 256)) % 256);
`endif
  endfunction

  function automatic bq_t build_pkt(input bit sel, input logic [15:0] base, input int ndata, input bit good);
    bq_t         q;
    int          nb;
    logic [15:0] nn;
    logic [7:0]  c;
    nb = sel ? 2 : 1;
    nn = 16'(ndata - 1);
    q.push_back(8'h00);
    for (int i = nb - 1; i >= 0; i--) q.push_back(base[8*i +: 8]);
    for (int i = nb - 1; i >= 0; i--) q.push_back(nn[8*i +: 8]);
    for (int i = 0; i < ndata; i++) q.push_back(8'($urandom));
    c = good_chk(q);
    q[0] = good ? c : c + 8'd1;
    return q;
  endfunction

  // Send a packet, then compare writes and result against the model.
  task automatic run_packet(input bit sel, input bq_t pkt, input int hold_first,
                            input bit drop_en, input string name);
    int  nb, base, n, nd, w0, s0, e0, waited, exp_a;
    bit  good;
    wr_t got;
    nb = sel ? 2 : 1;
    base = 0; n = 0;
    for (int i = 0; i < nb; i++) base = (base << 8) | int'(pkt[1 + i]);
    for (int i = 0; i < nb; i++) n = (n << 8) | int'(pkt[1 + nb + i]);
    nd   = n + 1;
    good = model_good(pkt);
    w0 = wsize_of(sel); s0 = succ_of(sel); e0 = err_of(sel);
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(sel, pkt[i], (i == 0) ? hold_first : int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)));
      if (i == 0 && drop_en) set_en(sel, 1'b0);
    end
    waited = 0;
    while (succ_of(sel) == s0 && err_of(sel) == e0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    set_en(sel, 1'b1);
    checks++;
    if (wsize_of(sel) - w0 !== nd) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wsize_of(sel) - w0, nd);
    end
    for (int i = 0; i < nd && (w0 + i) < wsize_of(sel); i++) begin
      got   = wget(sel, w0 + i);
      exp_a = (base + i) % (1 << (8 * nb));
      checks++;
      if (got.a !== 16'(exp_a) || got.d !== pkt[1 + 2*nb + i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got %h/%h expected %h/%h", name, i, got.a, got.d,
                 16'(exp_a), pkt[1 + 2*nb + i]);
      end
    end
    checks++;
    if (succ_of(sel) - s0 !== (good ? 1 : 0)) begin
      errors++;
      $display("FAIL %s success_ticks: got %0d expected %0d", name, succ_of(sel) - s0, good ? 1 : 0);
    end
    checks++;
    if (err_of(sel) - e0 !== (good ? 0 : 1)) begin
      errors++;
      $display("FAIL %s error_ticks: got %0d expected %0d", name, err_of(sel) - e0, good ? 0 : 1);
    end
    checks++;
    if (errc_of(sel) !== (good ? 2'd0 : 2'd1)) begin
      errors++;
      $display("FAIL %s err_code: got %0d expected %0d", name, errc_of(sel), good ? 0 : 1);
    end
    checks++;
    if (busy_of(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: got %b expected 0", name, busy_of(sel));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus_a.en = 1'b1; bus_b.en = 1'b1;
    set_rx(1'b0, 1'b0, 8'h00);
    set_rx(1'b1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.addr_out, bus_a.data_out} !== 16'h0) begin
      errors++; $display("FAIL reset_a_bus: got %h expected 0", {bus_a.addr_out, bus_a.data_out});
    end
    checks++;
    if ({bus_a.write_tick, bus_a.success_tick, bus_a.error_tick, bus_a.busy} !== 4'b0) begin
      errors++; $display("FAIL reset_a_flags: got %b expected 0000",
                         {bus_a.write_tick, bus_a.success_tick, bus_a.error_tick, bus_a.busy});
    end
    checks++;
    if (bus_a.err_code !== 2'd0 || bus_a.current_count !== 8'd0) begin
      errors++; $display("FAIL reset_a_code: got %0d/%0d expected 0/0", bus_a.err_code, bus_a.current_count);
    end
    checks++;
    if ({bus_b.addr_out, bus_b.data_out, bus_b.current_count} !== 40'h0) begin
      errors++; $display("FAIL reset_b_bus: got %h expected 0",
                         {bus_b.addr_out, bus_b.data_out, bus_b.current_count});
    end
    checks++;
    if ({bus_b.write_tick, bus_b.success_tick, bus_b.error_tick, bus_b.busy, bus_b.err_code} !== 6'b0) begin
      errors++; $display("FAIL reset_b_flags: got %b expected 0",
                         {bus_b.write_tick, bus_b.success_tick, bus_b.error_tick, bus_b.busy, bus_b.err_code});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    bq_t pkt;
    int  w0;
    pkt = '{8'hF0, 8'h10, 8'h01, 8'hAA, 8'h55};
`ifdef PACKET_PARSER_CRC8_EN
    pkt[0] = crc8_msg(pkt, 1);
`endif
    w0 = wq_a.size();
    run_packet(1'b0, pkt, 1, 1'b0, "dir_good");
    checks++;
    if (wq_a.size() < w0 + 2 || wq_a[w0] !== wr_t'({16'h0010, 8'hAA}) ||
        wq_a[w0 + 1] !== wr_t'({16'h0011, 8'h55})) begin
      errors++; $display("FAIL dir_good_writes: got %0d writes, expected (10,AA),(11,55)", wq_a.size() - w0);
    end
    pkt[0] = pkt[0] + 8'd1;
    run_packet(1'b0, pkt, 1, 1'b0, "dir_bad");
    checks++;
    if (bus_a.err_code !== 2'd1) begin
      errors++; $display("FAIL dir_bad_code: got %0d expected 1", bus_a.err_code);
    end
  endtask

  task automatic test_wrap();
    bq_t pkt;
    int  w0;
    pkt = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
    pkt[0] = good_chk(pkt);
    w0 = wq_b.size();
    run_packet(1'b1, pkt, 1, 1'b0, "wrap16");
    checks++;
    if (wq_b.size() < w0 + 3 || wq_b[w0] !== wr_t'({16'hFFFF, 8'h01}) ||
        wq_b[w0 + 1] !== wr_t'({16'h0000, 8'h02}) || wq_b[w0 + 2] !== wr_t'({16'h0001, 8'h03})) begin
      errors++; $display("FAIL wrap16_addrs: got %0d writes, expected FFFF,0000,0001", wq_b.size() - w0);
    end
    // Largest packet: count FF -> 256 bytes, address wrapping past FF.
    run_packet(1'b0, build_pkt(1'b0, 16'h0080, 256, 1'b1), 1, 1'b0, "max_count");
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_packet(1'b0, build_pkt(1'b0, 16'($urandom), int'($urandom_range(1, 6)), 1'($urandom)),
                 int'($urandom_range(1, 3)), 1'b0, "rand_a");
      run_packet(1'b1, build_pkt(1'b1, 16'($urandom), int'($urandom_range(1, 6)), 1'($urandom)),
                 int'($urandom_range(1, 3)), 1'b0, "rand_b");
    end
  endtask

  task automatic test_timeout();
    bq_t pkt;
    int  e0, w0, s0, lat;
    pkt = build_pkt(1'b0, 16'($urandom), 2, 1'b1);
    e0 = err_a; w0 = wq_a.size();
    send_byte(1'b0, pkt[0], 1, 0);
    @(negedge clk);
    set_rx(1'b0, 1'b1, pkt[1]);
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) set_rx(1'b0, 1'b0, pkt[1]);
      if (err_a != e0) begin lat = i; break; end
    end
    checks++;
    if (lat < 100 || lat > 102) begin
      errors++; $display("FAIL timeout_latency: got %0d expected 100..102", lat);
    end
    checks++;
    if (bus_a.err_code !== 2'd2 || bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_state: got code %0d busy %b expected 2/0", bus_a.err_code, bus_a.busy);
    end
    checks++;
    if (wq_a.size() != w0) begin
      errors++; $display("FAIL timeout_writes: got %0d expected 0", wq_a.size() - w0);
    end
    repeat (3) @(negedge clk);
    run_packet(1'b0, build_pkt(1'b0, 16'($urandom), 3, 1'b1), 1, 1'b0, "after_timeout");

    // Timeout disabled on B: a long stall leaves the packet open.
    pkt = build_pkt(1'b1, 16'($urandom), 1, 1'b1);
    e0 = err_b; w0 = wq_b.size(); s0 = succ_b;
    for (int i = 0; i < 5; i++) send_byte(1'b1, pkt[i], 1, 1);
    repeat (300) @(negedge clk);
    checks++;
    if (bus_b.busy !== 1'b1 || err_b != e0) begin
      errors++; $display("FAIL no_timeout_b: got busy %b errors %0d expected 1/0", bus_b.busy, err_b - e0);
    end
    send_byte(1'b1, pkt[5], 1, 4);
    checks++;
    if (wq_b.size() != w0 + 1 || succ_b != s0 + 1 ||
        wq_b[w0] !== wr_t'({pkt[1], pkt[2], pkt[5]})) begin
      errors++; $display("FAIL no_timeout_b_finish: got %0d writes %0d success expected 1/1",
                         wq_b.size() - w0, succ_b - s0);
    end
  endtask

  task automatic test_hold_and_en();
    int w0, s0, e0;
    set_en(1'b0, 1'b0);
    w0 = wq_a.size(); s0 = succ_a; e0 = err_a;
    for (int i = 0; i < 3; i++) begin
      send_byte(1'b0, 8'($urandom), 2, 1);
      checks++;
      if (bus_a.busy !== 1'b0) begin
        errors++; $display("FAIL en_low_busy: got %b expected 0 (byte %0d)", bus_a.busy, i);
      end
    end
    checks++;
    if (wq_a.size() != w0 || succ_a != s0 || err_a != e0) begin
      errors++; $display("FAIL en_low_ticks: got %0d events expected 0",
                         (wq_a.size() - w0) + (succ_a - s0) + (err_a - e0));
    end
    set_en(1'b0, 1'b1);
    run_packet(1'b0, build_pkt(1'b0, 16'($urandom), 2, 1'b1), 20, 1'b0, "hold20");
    run_packet(1'b0, build_pkt(1'b0, 16'($urandom), 3, 1'b1), 1, 1'b1, "en_drop");
  endtask

  task automatic test_reset_mid();
    bq_t pkt;
    int  w0, s0, e0;
    pkt = build_pkt(1'b0, 16'($urandom), 4, 1'b1);
    w0 = wq_a.size(); s0 = succ_a; e0 = err_a;
    for (int i = 0; i < 5; i++) send_byte(1'b0, pkt[i], 1, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.addr_out, bus_a.data_out, bus_a.busy, bus_a.write_tick, bus_a.err_code} !== 21'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0",
                         {bus_a.addr_out, bus_a.data_out, bus_a.busy, bus_a.write_tick, bus_a.err_code});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (succ_a != s0 || err_a != e0 || wq_a.size() != w0 + 2) begin
      errors++; $display("FAIL reset_mid_ticks: got %0d/%0d/%0d expected 0/0/2",
                         succ_a - s0, err_a - e0, wq_a.size() - w0);
    end
    run_packet(1'b0, build_pkt(1'b0, 16'($urandom), 3, 1'b1), 1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_random();
    test_timeout();
    test_hold_and_en();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
